// File: rtl/cayde_wb_arbiter.sv
// cayde_wb_arbiter: write-back arbiter for the cayde register file.
// Merges ALU results (never stalled) and LSU results (valid/ready, buffered in a
// small FIFO) onto the single registered regfile write port.
// Optional build macro: CAYDE_WB_BYPASS_EN adds a two-port read bypass from the
// write stage register.

`timescale 1ns/1ps

module cayde_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid_in,
    input  logic [4:0]                 alu_rd_in,
    input  logic [XLEN-1:0]            alu_data_in,
    input  logic                       lsu_valid_in,
    output logic                       lsu_ready_out,
    input  logic [4:0]                 lsu_rd_in,
    input  logic [XLEN-1:0]            lsu_data_in,
    output logic [4:0]                 waddr_out,
    output logic [XLEN-1:0]            wdata_out,
    output logic                       wen_out,
    output logic [$clog2(DEPTH):0]     pend_count_out
`ifdef CAYDE_WB_BYPASS_EN
    ,
    input  logic [4:0]                 raddr_in1,
    input  logic [4:0]                 raddr_in2,
    output logic                       byp_hit_out1,
    output logic                       byp_hit_out2,
    output logic [XLEN-1:0]            byp_data_out1,
    output logic [XLEN-1:0]            byp_data_out2
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Pointers wrap for free only when DEPTH is a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("cayde_wb_arbiter: DEPTH must be a power of 2 and >= 2");
    end

    // FIFO storage and bookkeeping
    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Write stage register
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wen_q, wen_d;

    // Selection signals
    logic            fifo_empty;
    logic            fifo_full;
    logic            lsu_hs;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            push;
    logic            pop;

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == CW'(DEPTH));
    // Ready depends on registered occupancy only, so a same-cycle pop never raises it.
    assign lsu_ready_out = !fifo_full;
    assign lsu_hs        = lsu_valid_in && lsu_ready_out;

    // Priority select: ALU, then FIFO head, then LSU bypass when the FIFO is empty.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        pop       = 1'b0;
        push      = 1'b0;
        if (alu_valid_in) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd_in;
            sel_data  = alu_data_in;
            push      = lsu_hs;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
            pop       = 1'b1;
            push      = lsu_hs;
        end else if (lsu_hs) begin
            sel_valid = 1'b1;
            sel_rd    = lsu_rd_in;
            sel_data  = lsu_data_in;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write stage next-state; x0 writes still update address/data but never enable.
    always_comb begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        if (sel_valid) begin
            waddr_d = sel_rd;
            wdata_d = sel_data;
            wen_d   = (sel_rd != 5'd0);
        end
    end

    // Control and write stage state, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
        end
    end

    // FIFO payload storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_rd_q[wr_ptr_q]   <= lsu_rd_in;
            fifo_data_q[wr_ptr_q] <= lsu_data_in;
        end
    end

    assign waddr_out      = waddr_q;
    assign wdata_out      = wdata_q;
    assign wen_out        = wen_q;
    assign pend_count_out = count_q;

`ifdef CAYDE_WB_BYPASS_EN
    // Forward the pending write to readers during the cycle before the regfile commits.
    always_comb begin
        byp_hit_out1  = wen_q && (waddr_q == raddr_in1) && (raddr_in1 != 5'd0);
        byp_hit_out2  = wen_q && (waddr_q == raddr_in2) && (raddr_in2 != 5'd0);
        byp_data_out1 = byp_hit_out1 ? wdata_q : '0;
        byp_data_out2 = byp_hit_out2 ? wdata_q : '0;
    end
`endif

endmodule

// File: tb/tb_cayde_wb_arbiter.sv
// Directed self-checking bench for cayde_wb_arbiter (DEPTH=4, XLEN=32).

`timescale 1ns/1ps

module tb_cayde_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_in;
    logic [4:0]  alu_rd_in;
    logic [31:0] alu_data_in;
    logic        lsu_valid_in;
    logic        lsu_ready_out;
    logic [4:0]  lsu_rd_in;
    logic [31:0] lsu_data_in;
    logic [4:0]  waddr_out;
    logic [31:0] wdata_out;
    logic        wen_out;
    logic [2:0]  pend_count_out;
`ifdef CAYDE_WB_BYPASS_EN
    logic [4:0]  raddr_in1, raddr_in2;
    logic        byp_hit_out1, byp_hit_out2;
    logic [31:0] byp_data_out1, byp_data_out2;
`endif

    int tests = 0;
    int fails = 0;

    cayde_wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid_in   (alu_valid_in),
        .alu_rd_in      (alu_rd_in),
        .alu_data_in    (alu_data_in),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_ready_out  (lsu_ready_out),
        .lsu_rd_in      (lsu_rd_in),
        .lsu_data_in    (lsu_data_in),
        .waddr_out      (waddr_out),
        .wdata_out      (wdata_out),
        .wen_out        (wen_out),
        .pend_count_out (pend_count_out)
`ifdef CAYDE_WB_BYPASS_EN
        ,
        .raddr_in1      (raddr_in1),
        .raddr_in2      (raddr_in2),
        .byp_hit_out1   (byp_hit_out1),
        .byp_hit_out2   (byp_hit_out2),
        .byp_data_out1  (byp_data_out1),
        .byp_data_out2  (byp_data_out2)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int next_rd;
    int nwr;
    bit hs;

    initial begin
        rst = 1'b1;
        alu_valid_in = 1'b0; alu_rd_in = '0; alu_data_in = '0;
        lsu_valid_in = 1'b0; lsu_rd_in = '0; lsu_data_in = '0;
`ifdef CAYDE_WB_BYPASS_EN
        raddr_in1 = '0; raddr_in2 = '0;
`endif
        tick();
        tick();
        check("rst_wen",   {63'd0, wen_out}, 64'd0);
        check("rst_waddr", {59'd0, waddr_out}, 64'd0);
        check("rst_wdata", {32'd0, wdata_out}, 64'd0);
        check("rst_pend",  {61'd0, pend_count_out}, 64'd0);
        check("rst_ready", {63'd0, lsu_ready_out}, 64'd1);
        rst = 1'b0;
        tick();
        check("idle_wen", {63'd0, wen_out}, 64'd0);

        // 1: single ALU write, then idle holds address/data
        alu_valid_in = 1'b1; alu_rd_in = 5'd5; alu_data_in = 32'hDEADBEEF;
        tick();
        alu_valid_in = 1'b0;
        check("t1_wen",   {63'd0, wen_out}, 64'd1);
        check("t1_waddr", {59'd0, waddr_out}, 64'd5);
        check("t1_wdata", {32'd0, wdata_out}, 64'hDEADBEEF);
        tick();
        check("t1_wen_off",  {63'd0, wen_out}, 64'd0);
        check("t1_hold_adr", {59'd0, waddr_out}, 64'd5);
        check("t1_hold_dat", {32'd0, wdata_out}, 64'hDEADBEEF);

        // 2: LSU bypass with empty FIFO
        lsu_valid_in = 1'b1; lsu_rd_in = 5'd7; lsu_data_in = 32'h12;
        check("t2_ready", {63'd0, lsu_ready_out}, 64'd1);
        tick();
        lsu_valid_in = 1'b0;
        check("t2_wen",   {63'd0, wen_out}, 64'd1);
        check("t2_waddr", {59'd0, waddr_out}, 64'd7);
        check("t2_wdata", {32'd0, wdata_out}, 64'h12);
        check("t2_pend",  {61'd0, pend_count_out}, 64'd0);

        // 3: ALU busy 6 cycles while LSU offers rd=1..6; FIFO fills at 4
        next_rd = 1;
        for (int i = 1; i <= 6; i++) begin
            alu_valid_in = 1'b1; alu_rd_in = 5'(20 + i); alu_data_in = 32'(i);
            lsu_valid_in = 1'b1; lsu_rd_in = 5'(next_rd); lsu_data_in = 32'(256 + next_rd);
            hs = lsu_ready_out;
            tick();
            if (hs) next_rd++;
            check("t3_alu_waddr", {59'd0, waddr_out}, 64'(20 + i));
            check("t3_alu_wen",   {63'd0, wen_out}, 64'd1);
            if (i == 4) begin
                check("t3_full_ready", {63'd0, lsu_ready_out}, 64'd0);
                check("t3_full_pend",  {61'd0, pend_count_out}, 64'd4);
            end
        end
        check("t3_accepted", 64'(next_rd - 1), 64'd4);
        alu_valid_in = 1'b0;
        // Drain: expect rd=1..6 in order, one per cycle
        nwr = 0;
        for (int c = 0; c < 20; c++) begin
            lsu_valid_in = (next_rd <= 6);
            lsu_rd_in    = 5'(next_rd);
            lsu_data_in  = 32'(256 + next_rd);
            hs = lsu_valid_in && lsu_ready_out;
            tick();
            if (hs) next_rd++;
            if (wen_out) begin
                nwr++;
                check("t3_order", {59'd0, waddr_out}, 64'(nwr));
                check("t3_data",  {32'd0, wdata_out}, 64'(256 + nwr));
            end
        end
        lsu_valid_in = 1'b0;
        check("t3_nwrites", 64'(nwr), 64'd6);
        check("t3_pend_end", {61'd0, pend_count_out}, 64'd0);

        // 4: writes to x0 never enable, but address/data update
        alu_valid_in = 1'b1; alu_rd_in = 5'd0; alu_data_in = 32'hFFFFFFFF;
        tick();
        alu_valid_in = 1'b0;
        check("t4_wen",   {63'd0, wen_out}, 64'd0);
        check("t4_waddr", {59'd0, waddr_out}, 64'd0);
        check("t4_wdata", {32'd0, wdata_out}, 64'hFFFFFFFF);
        lsu_valid_in = 1'b1; lsu_rd_in = 5'd0; lsu_data_in = 32'h77;
        tick();
        lsu_valid_in = 1'b0;
        check("t4_lsu_wen",  {63'd0, wen_out}, 64'd0);
        check("t4_lsu_data", {32'd0, wdata_out}, 64'h77);
        check("t4_lsu_pend", {61'd0, pend_count_out}, 64'd0);

        // 5: three buffered entries discarded by reset
        for (int i = 0; i < 3; i++) begin
            alu_valid_in = 1'b1; alu_rd_in = 5'd30; alu_data_in = 32'h30;
            lsu_valid_in = 1'b1; lsu_rd_in = 5'(11 + i); lsu_data_in = 32'(11 + i);
            tick();
        end
        alu_valid_in = 1'b0; lsu_valid_in = 1'b0;
        check("t5_pend3", {61'd0, pend_count_out}, 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_pend",  {61'd0, pend_count_out}, 64'd0);
        check("t5_wen",   {63'd0, wen_out}, 64'd0);
        check("t5_ready", {63'd0, lsu_ready_out}, 64'd1);
        check("t5_waddr", {59'd0, waddr_out}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_no_stale", {63'd0, wen_out}, 64'd0);
        end

`ifdef CAYDE_WB_BYPASS_EN
        // 6: bypass from the write stage register
        alu_valid_in = 1'b1; alu_rd_in = 5'd9; alu_data_in = 32'hA5A5;
        tick();
        alu_valid_in = 1'b0;
        raddr_in1 = 5'd9; raddr_in2 = 5'd8;
        #1;
        check("t6_hit1",  {63'd0, byp_hit_out1}, 64'd1);
        check("t6_data1", {32'd0, byp_data_out1}, 64'hA5A5);
        check("t6_hit2",  {63'd0, byp_hit_out2}, 64'd0);
        check("t6_data2", {32'd0, byp_data_out2}, 64'd0);
        raddr_in1 = 5'd0;
        #1;
        check("t6_x0_hit", {63'd0, byp_hit_out1}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
